// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle sequencer and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_PERF_CNT_EN to add the instret and stall_cnt performance counters.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master mem,
  input  logic [31:0]       instruction,
  input  logic              zero,
  output logic              IRWr,
  output logic              PCWr,
  output logic [1:0]        nPC_sel,
  output logic              j_sel,
  output logic              RegDst,
  output logic              RegWr,
  output logic [1:0]        ExtOp,
  output logic              ALUSrc,
  output logic [1:0]        ALUctr,
  output logic              MemtoReg,
  output logic              MemWr,
  output logic              illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]       instret,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ILL, OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J
  } op_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] ext_op;
    logic       alu_src;
    logic [1:0] alu_ctr;
    logic       mem_to_reg;
    logic       j_sel;
  } dec_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       reg_wr;
    logic       mem_wr;
    logic       illegal;
  } ctl_t;

  function automatic op_t classify(input logic [5:0] opcode, input logic [5:0] funct);
    op_t op;
    op = OP_ILL;
    case (opcode)
      6'h00: begin
        if (funct == 6'h21)      op = OP_ADDU;
        else if (funct == 6'h23) op = OP_SUBU;
      end
      6'h0D:   op = OP_ORI;
      6'h0F:   op = OP_LUI;
      6'h23:   op = OP_LW;
      6'h2B:   op = OP_SW;
      6'h04:   op = OP_BEQ;
      6'h02:   op = OP_J;
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic dec_t encode(input op_t op);
    dec_t d;
    d = '0;
    case (op)
      OP_ADDU: d.reg_dst = 1'b1;
      OP_SUBU: begin d.reg_dst = 1'b1; d.alu_ctr = 2'b01; end
      OP_ORI:  begin d.alu_src = 1'b1; d.alu_ctr = 2'b10; end
      OP_LUI:  begin d.ext_op = 2'b10; d.alu_src = 1'b1; d.alu_ctr = 2'b10; end
      OP_LW:   begin d.ext_op = 2'b01; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; end
      OP_SW:   begin d.ext_op = 2'b01; d.alu_src = 1'b1; end
      OP_BEQ:  begin d.ext_op = 2'b01; d.alu_ctr = 2'b01; end
      OP_J:    d.j_sel = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t state, state_nxt;
  op_t    op_q, op_cur;
  dec_t   dec;
  ctl_t   ctl;
  logic   done;

  logic unused_fields;
  assign unused_fields = ^instruction[25:6];

  // Decode is live from the IR in DECODE, then held from the captured opcode class.
  assign op_cur = (state == S_DECODE) ? classify(instruction[31:26], instruction[5:0]) : op_q;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    dec       = '0;
    ctl       = '0;
    done      = 1'b0;
    case (state)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ctl.ir_wr = 1'b1;
          ctl.pc_wr = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        dec = encode(op_cur);
        if (op_cur == OP_J) begin
          ctl.pc_wr   = 1'b1;
          ctl.npc_sel = 2'b01;
          done        = 1'b1;
          state_nxt   = S_FETCH;
        end else if (op_cur == OP_ILL) begin
          ctl.illegal = 1'b1;
          state_nxt   = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        dec = encode(op_q);
        if (op_q == OP_BEQ) begin
          ctl.npc_sel = 2'b10;
          ctl.pc_wr   = zero;
          done        = 1'b1;
          state_nxt   = S_FETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dec         = encode(op_q);
        ctl.mem_req = 1'b1;
        ctl.mem_we  = (op_q == OP_SW);
        if (mem.mem_ready) begin
          if (op_q == OP_SW) begin
            ctl.mem_wr = 1'b1;
            done       = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        dec        = encode(op_q);
        ctl.reg_wr = 1'b1;
        done       = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset dominates: no request or strobe escapes while rst_n is low.
    if (!rst_n) begin
      dec  = '0;
      ctl  = '0;
      done = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      op_q  <= OP_ILL;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= op_cur;
    end
  end

  assign mem.mem_req = ctl.mem_req;
  assign mem.mem_we  = ctl.mem_we;
  assign IRWr        = ctl.ir_wr;
  assign PCWr        = ctl.pc_wr;
  assign nPC_sel     = ctl.npc_sel;
  assign RegWr       = ctl.reg_wr;
  assign MemWr       = ctl.mem_wr;
  assign illegal     = ctl.illegal;
  assign j_sel       = dec.j_sel;
  assign RegDst      = dec.reg_dst;
  assign ExtOp       = dec.ext_op;
  assign ALUSrc      = dec.alu_src;
  assign ALUctr      = dec.alu_ctr;
  assign MemtoReg    = dec.mem_to_reg;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      if (done) instret <= instret + 32'd1;
      if (ctl.mem_req && !mem.mem_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction cycle-trace model predicts every output each cycle.
module tb_multicycle_ctrl;

  localparam int K_ILL  = 0;
  localparam int K_ADDU = 1;
  localparam int K_SUBU = 2;
  localparam int K_ORI  = 3;
  localparam int K_LUI  = 4;
  localparam int K_LW   = 5;
  localparam int K_SW   = 6;
  localparam int K_BEQ  = 7;
  localparam int K_J    = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       j_sel;
    logic       reg_dst;
    logic       reg_wr;
    logic [1:0] ext_op;
    logic       alu_src;
    logic [1:0] alu_ctr;
    logic       mem_to_reg;
    logic       mem_wr;
    logic       illegal;
  } obs_t;

  typedef struct {
    logic        ready;
    logic        zero;
    logic [31:0] instr;
    obs_t        exp;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        zero = 1'b0;
  logic        IRWr, PCWr, j_sel, RegDst, RegWr, ALUSrc, MemtoReg, MemWr, illegal;
  logic [1:0]  nPC_sel, ExtOp, ALUctr;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instret, stall_cnt;
`endif

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (bus),
    .instruction (instruction),
    .zero        (zero),
    .IRWr        (IRWr),
    .PCWr        (PCWr),
    .nPC_sel     (nPC_sel),
    .j_sel       (j_sel),
    .RegDst      (RegDst),
    .RegWr       (RegWr),
    .ExtOp       (ExtOp),
    .ALUSrc      (ALUSrc),
    .ALUctr      (ALUctr),
    .MemtoReg    (MemtoReg),
    .MemWr       (MemWr),
    .illegal     (illegal)
`ifdef MC_PERF_CNT_EN
    ,
    .instret     (instret),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  obs_t got;
  always_comb got = {bus.mem_req, bus.mem_we, IRWr, PCWr, nPC_sel, j_sel, RegDst, RegWr,
                     ExtOp, ALUSrc, ALUctr, MemtoReg, MemWr, illegal};

  int    checks = 0;
  int    errors = 0;
  step_t steps[$];
  int    instret_m = 0;
  int    stall_m = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Decode-field encodings each instruction class must present from DECODE to its last state.
  function automatic obs_t dec_fields(input int k);
    obs_t o;
    o = '0;
    case (k)
      K_ADDU: o.reg_dst = 1'b1;
      K_SUBU: begin o.reg_dst = 1'b1; o.alu_ctr = 2'b01; end
      K_ORI:  begin o.alu_src = 1'b1; o.alu_ctr = 2'b10; end
      K_LUI:  begin o.ext_op = 2'b10; o.alu_src = 1'b1; o.alu_ctr = 2'b10; end
      K_LW:   begin o.ext_op = 2'b01; o.alu_src = 1'b1; o.mem_to_reg = 1'b1; end
      K_SW:   begin o.ext_op = 2'b01; o.alu_src = 1'b1; end
      K_BEQ:  begin o.ext_op = 2'b01; o.alu_ctr = 2'b01; end
      K_J:    o.j_sel = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Builds the expected cycle-by-cycle trace of one instruction with fw fetch waits and mw data waits.
  task automatic plan(input int k, input logic [31:0] ins, input int fw, input int mw, input logic z);
    step_t s;
    obs_t  d;
    d = dec_fields(k);
    steps.delete();
    for (int i = 0; i < fw; i++) begin
      s.ready = 1'b0; s.zero = 1'($urandom); s.instr = $urandom;
      s.exp = '0; s.exp.mem_req = 1'b1;
      steps.push_back(s);
    end
    s.ready = 1'b1; s.zero = 1'($urandom); s.instr = $urandom;
    s.exp = '0; s.exp.mem_req = 1'b1; s.exp.ir_wr = 1'b1; s.exp.pc_wr = 1'b1;
    steps.push_back(s);
    s.ready = 1'b1 & 1'($urandom); s.zero = 1'($urandom); s.instr = ins; s.exp = d;
    if (k == K_ILL) begin s.exp.illegal = 1'b1; steps.push_back(s); return; end
    if (k == K_J) begin s.exp.pc_wr = 1'b1; s.exp.npc_sel = 2'b01; steps.push_back(s); return; end
    steps.push_back(s);
    s.ready = 1'($urandom); s.zero = 1'($urandom); s.exp = d;
    if (k == K_BEQ) begin
      s.zero = z; s.exp.npc_sel = 2'b10; s.exp.pc_wr = z;
      steps.push_back(s);
      return;
    end
    steps.push_back(s);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < mw; i++) begin
        s.ready = 1'b0; s.zero = 1'($urandom); s.exp = d;
        s.exp.mem_req = 1'b1; s.exp.mem_we = (k == K_SW);
        steps.push_back(s);
      end
      s.ready = 1'b1; s.zero = 1'($urandom); s.exp = d;
      s.exp.mem_req = 1'b1; s.exp.mem_we = (k == K_SW); s.exp.mem_wr = (k == K_SW);
      steps.push_back(s);
      if (k == K_SW) return;
    end
    s.ready = 1'($urandom); s.zero = 1'($urandom); s.exp = d; s.exp.reg_wr = 1'b1;
    steps.push_back(s);
  endtask

  task automatic check_counters(input string tag);
`ifdef MC_PERF_CNT_EN
    check({tag, "_instret"}, instret, instret_m);
    check({tag, "_stall"}, stall_cnt, stall_m);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Plays one instruction; abort_at >= 0 pulls rst_n low on that step instead of finishing.
  task automatic run(input string tag, input int k, input logic [31:0] ins, input int fw,
                     input int mw, input logic z, input int abort_at);
    plan(k, ins, fw, mw, z);
    foreach (steps[i]) begin
      @(negedge clk);
      instruction   = steps[i].instr;
      zero          = steps[i].zero;
      bus.mem_ready = steps[i].ready;
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1 check($sformatf("%s_rst[%0d]", tag, i), 32'(got), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        instret_m = 0;
        stall_m   = 0;
        check_counters({tag, "_rst"});
        return;
      end
      #1 check($sformatf("%s[%0d]", tag, i), 32'(got), 32'(steps[i].exp));
    end
    @(posedge clk);
    #1;
    if (k != K_ILL) instret_m++;
    stall_m += fw + ((k == K_LW || k == K_SW) ? mw : 0);
    check_counters(tag);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom);
      instruction   = $urandom;
      #1 check($sformatf("reset[%0d]", i), 32'(got), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    instret_m = 0;
    stall_m   = 0;
    check_counters("reset");
  endtask

  task automatic gen(output int k, output logic [31:0] ins);
    logic [31:0] r;
    logic [5:0]  op, fn;
    r = $urandom;
    k = $urandom_range(0, 8);
    case (k)
      K_ADDU: ins = {6'h00, r[25:6], 6'h21};
      K_SUBU: ins = {6'h00, r[25:6], 6'h23};
      K_ORI:  ins = {6'h0D, r[25:0]};
      K_LUI:  ins = {6'h0F, r[25:0]};
      K_LW:   ins = {6'h23, r[25:0]};
      K_SW:   ins = {6'h2B, r[25:0]};
      K_BEQ:  ins = {6'h04, r[25:0]};
      K_J:    ins = {6'h02, r[25:0]};
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          do fn = 6'($urandom); while (fn == 6'h21 || fn == 6'h23);
          ins = {6'h00, r[25:6], fn};
        end else begin
          do op = 6'($urandom);
          while (op inside {6'h00, 6'h02, 6'h04, 6'h0D, 6'h0F, 6'h23, 6'h2B});
          ins = {op, r[25:0]};
        end
      end
    endcase
  endtask

  initial begin
    int          k, ab;
    logic [31:0] ins;
    bus.mem_ready = 1'b0;
    do_reset(3);

    run("addu",   K_ADDU, 32'h0022_1821, 0, 0, 1'b0, -1);
    run("lw_w2",  K_LW,   32'h8C22_0004, 0, 2, 1'b0, -1);
    run("beq_z1", K_BEQ,  32'h1022_0003, 0, 0, 1'b1, -1);
    run("beq_z0", K_BEQ,  32'h1022_0003, 0, 0, 1'b0, -1);
    run("j",      K_J,    32'h0800_0010, 0, 0, 1'b0, -1);
    run("ill3f",  K_ILL,  32'hFC00_0000, 0, 0, 1'b0, -1);
    run("sw_rst", K_SW,   32'hAC22_0004, 0, 2, 1'b0, 4);
    run("post",   K_ORI,  32'h3422_00FF, 1, 0, 1'b0, -1);

    do_reset(1);
    run("perf_addu", K_ADDU, 32'h0022_1821, 1, 0, 1'b0, -1);
    run("perf_sw",   K_SW,   32'hAC22_0004, 1, 0, 1'b0, -1);
    run("perf_j",    K_J,    32'h0800_0010, 1, 0, 1'b0, -1);
`ifdef MC_PERF_CNT_EN
    check("perf_instret3", instret, 32'd3);
    check("perf_stall3", stall_cnt, 32'd3);
`endif

    for (int n = 0; n < 300; n++) begin
      gen(k, ins);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1;
      run($sformatf("rnd%0d", n), k, ins, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
